// File: rtl/mem_sync_be_pipe_if.sv
// Request/response bus for mem_sync_be_pipe.
//   master: drives REQ, WE, ADDR, WDATA, BE; receives RDATA, ACK, ERR, BUSY.
//   slave : the memory side of the same bundle.
interface mem_sync_be_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic                  REQ;
  logic                  WE;
  logic [ADDR_W-1:0]     ADDR;
  logic [DATA_W-1:0]     WDATA;
  logic [DATA_W/8-1:0]   BE;
  logic [DATA_W-1:0]     RDATA;
  logic                  ACK;
  logic                  ERR;
  logic                  BUSY;

  modport master (
    output REQ, WE, ADDR, WDATA, BE,
    input  RDATA, ACK, ERR, BUSY
  );

  modport slave (
    input  REQ, WE, ADDR, WDATA, BE,
    output RDATA, ACK, ERR, BUSY
  );
endinterface

// File: rtl/mem_sync_be_pipe.sv
// Single-port synchronous word memory with byte enables, REQ/ACK handshake,
// fixed response latency and a hardware clear sequence after reset.
//   CLK  : clock, all state changes on the rising edge
//   RST  : synchronous active-high reset
//   bus  : slave side of mem_sync_be_pipe_if
//          REQ/WE/ADDR/WDATA/BE in, RDATA/ACK/ERR/BUSY out
// Every accepted request produces exactly one ACK, RD_LATENCY cycles after
// acceptance, in order. ERR flags ADDR >= DEPTH; such requests never touch
// the array and reads return 0. RDATA only changes on read responses.
module mem_sync_be_pipe #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_W     = 8,
  parameter int RD_LATENCY = 2
) (
  input logic              CLK,
  input logic              RST,
  mem_sync_be_pipe_if.slave bus
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {INIT, READY} state_t;

  typedef struct packed {
    logic              vld;
    logic              err;
    logic [DATA_W-1:0] data;
  } rsp_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_cnt;
  logic                busy;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                acc;
  logic                oor;
  logic                rd;
  logic                wr_hit;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    clr_idx;
  logic [DATA_W-1:0]   in_data;
  logic [DATA_W-1:0]   last_rd;
  rsp_t                in_rsp;
  rsp_t                stg [RD_LATENCY];

  // Clear sequencer: one word per cycle, BUSY drops on the edge that
  // clears the last word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= INIT;
      clr_cnt <= '0;
      busy    <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
            state <= READY;
            busy  <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: busy <= 1'b0;
      endcase
    end
  end

  assign acc     = bus.REQ && !busy && !RST;
  assign oor     = 32'(bus.ADDR) >= 32'(DEPTH);
  assign rd      = acc && !bus.WE;
  assign wr_hit  = acc && bus.WE && !oor;
  assign idx     = bus.ADDR[IDX_W-1:0];
  assign clr_idx = clr_cnt[IDX_W-1:0];

  // Array: clear writes during INIT, byte-masked writes afterwards.
  always_ff @(posedge CLK) begin
    if (!RST && state == INIT) begin
      mem[clr_idx] <= '0;
    end else if (wr_hit) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.BE[b]) mem[idx][8*b +: 8] <= bus.WDATA[8*b +: 8];
      end
    end
  end

  // Each stage carries the RDATA value to present when it reaches the
  // output. Writes and bubbles carry the last read result forward, so the
  // output simply follows the final stage and still "holds" on non-reads.
  always_comb begin
    in_data = last_rd;
    if (rd) in_data = oor ? '0 : mem[idx];
    in_rsp      = '0;
    in_rsp.vld  = acc;
    in_rsp.err  = acc && oor;
    in_rsp.data = in_data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_rd <= '0;
      for (int i = 0; i < RD_LATENCY; i++) stg[i] <= '0;
    end else begin
      last_rd <= in_data;
      stg[0]  <= in_rsp;
      for (int i = 1; i < RD_LATENCY; i++) stg[i] <= stg[i-1];
    end
  end

  assign bus.RDATA = stg[RD_LATENCY-1].data;
  assign bus.ACK   = stg[RD_LATENCY-1].vld;
  assign bus.ERR   = stg[RD_LATENCY-1].err;
  assign bus.BUSY  = busy;

endmodule

// File: tb/tb_mem_sync_be_pipe.sv
module tb_mem_sync_be_pipe;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cnt;
  int   ackbad;

  always #5 clk = ~clk;

  mem_sync_be_pipe_if #(.DATA_W(32), .ADDR_W(8)) b0 ();
  mem_sync_be_pipe_if #(.DATA_W(32), .ADDR_W(8)) b1 ();
  mem_sync_be_pipe_if #(.DATA_W(32), .ADDR_W(8)) b2 ();

  mem_sync_be_pipe #(.DATA_W(32), .DEPTH(256), .ADDR_W(8), .RD_LATENCY(2))
    u0 (.CLK(clk), .RST(rst), .bus(b0));
  mem_sync_be_pipe #(.DATA_W(32), .DEPTH(200), .ADDR_W(8), .RD_LATENCY(1))
    u1 (.CLK(clk), .RST(rst), .bus(b1));
  mem_sync_be_pipe #(.DATA_W(32), .DEPTH(16), .ADDR_W(8), .RD_LATENCY(4))
    u2 (.CLK(clk), .RST(rst), .bus(b2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic d0(input logic req, input logic we, input logic [7:0] a,
                    input logic [31:0] d, input logic [3:0] be);
    b0.REQ = req; b0.WE = we; b0.ADDR = a; b0.WDATA = d; b0.BE = be;
  endtask
  task automatic d1(input logic req, input logic we, input logic [7:0] a,
                    input logic [31:0] d, input logic [3:0] be);
    b1.REQ = req; b1.WE = we; b1.ADDR = a; b1.WDATA = d; b1.BE = be;
  endtask
  task automatic d2(input logic req, input logic we, input logic [7:0] a,
                    input logic [31:0] d, input logic [3:0] be);
    b2.REQ = req; b2.WE = we; b2.ADDR = a; b2.WDATA = d; b2.BE = be;
  endtask

  initial begin
    rst = 1'b1;
    d0(0, 0, 0, 0, 0); d1(0, 0, 0, 0, 0); d2(0, 0, 0, 0, 0);
    step(); step();
    chk("rst_ack",   32'(b0.ACK),   0);
    chk("rst_err",   32'(b0.ERR),   0);
    chk("rst_rdata", b0.RDATA,      0);
    chk("rst_busy",  32'(b0.BUSY),  1);

    // clear sequence length
    rst = 1'b0;
    cnt = 0;
    while (b0.BUSY === 1'b1 && cnt < 400) begin cnt++; step(); end
    chk("busy_cycles", cnt, 256);
    chk("u2_ready", 32'(b2.BUSY), 0);

    // read last word after clear
    d0(1, 0, 8'hFF, 0, 0); step(); d0(0, 0, 0, 0, 0);
    chk("ff_not_yet", 32'(b0.ACK), 0);
    step();
    chk("ff_ack",   32'(b0.ACK), 1);
    chk("ff_err",   32'(b0.ERR), 0);
    chk("ff_rdata", b0.RDATA, 32'h0);

    // byte enables
    d0(1, 1, 5, 32'hAABBCCDD, 4'b1111); step();
    d0(1, 1, 5, 32'h11223344, 4'b0101); step();
    chk("be_w1_ack", 32'(b0.ACK), 1);
    d0(1, 0, 5, 0, 0); step(); d0(0, 0, 0, 0, 0);
    chk("be_w2_ack",   32'(b0.ACK), 1);
    chk("be_w2_rdata", b0.RDATA, 32'h0);
    step();
    chk("be_rd_ack",   32'(b0.ACK), 1);
    chk("be_rd_rdata", b0.RDATA, 32'hAA22CC44);
    step();
    chk("be_idle_ack",  32'(b0.ACK), 0);
    chk("be_idle_hold", b0.RDATA, 32'hAA22CC44);

    // back-to-back write/read/read
    d0(1, 1, 3, 32'h12345678, 4'b1111); step();
    chk("b2b_none", 32'(b0.ACK), 0);
    d0(1, 0, 3, 0, 0); step();
    chk("b2b_w_ack", 32'(b0.ACK), 1);
    d0(1, 0, 4, 0, 0); step(); d0(0, 0, 0, 0, 0);
    chk("b2b_r3_ack",   32'(b0.ACK), 1);
    chk("b2b_r3_rdata", b0.RDATA, 32'h12345678);
    step();
    chk("b2b_r4_ack",   32'(b0.ACK), 1);
    chk("b2b_r4_rdata", b0.RDATA, 32'h0);
    step();
    chk("b2b_end", 32'(b0.ACK), 0);

    // out of range, DEPTH=200, latency 1
    d1(1, 1, 199, 32'hCAFEF00D, 4'b1111); step();
    chk("oor_w199_ack", 32'(b1.ACK), 1);
    chk("oor_w199_err", 32'(b1.ERR), 0);
    d1(1, 0, 199, 0, 0); step();
    chk("lat1_ack",   32'(b1.ACK), 1);
    chk("lat1_rdata", b1.RDATA, 32'hCAFEF00D);
    d1(1, 1, 250, 32'hFFFFFFFF, 4'b1111); step();
    chk("oor_w_ack",  32'(b1.ACK), 1);
    chk("oor_w_err",  32'(b1.ERR), 1);
    chk("oor_w_hold", b1.RDATA, 32'hCAFEF00D);
    d1(1, 0, 250, 0, 0); step();
    chk("oor_r_ack",   32'(b1.ACK), 1);
    chk("oor_r_err",   32'(b1.ERR), 1);
    chk("oor_r_rdata", b1.RDATA, 32'h0);
    d1(1, 0, 199, 0, 0); step();
    chk("r199_err",   32'(b1.ERR), 0);
    chk("r199_rdata", b1.RDATA, 32'hCAFEF00D);
    d1(1, 0, 200, 0, 0); step(); d1(0, 0, 0, 0, 0);
    chk("r200_err",   32'(b1.ERR), 1);
    chk("r200_rdata", b1.RDATA, 32'h0);
    step();
    chk("oor_idle_ack", 32'(b1.ACK), 0);
    chk("oor_idle_err", 32'(b1.ERR), 0);

    // latency 4
    d2(1, 1, 7, 32'h5A5AA5A5, 4'b1111); step(); d2(0, 0, 0, 0, 0);
    step(); step(); step();
    chk("lat4_w_ack", 32'(b2.ACK), 1);
    d2(1, 0, 7, 0, 0); step(); d2(0, 0, 0, 0, 0);
    chk("lat4_c1", 32'(b2.ACK), 0);
    step(); step();
    chk("lat4_c3", 32'(b2.ACK), 0);
    step();
    chk("lat4_ack",   32'(b2.ACK), 1);
    chk("lat4_rdata", b2.RDATA, 32'h5A5AA5A5);
    step();
    chk("lat4_end", 32'(b2.ACK), 0);

    // reset while reads are in flight
    d0(1, 0, 5, 0, 0); step();
    d0(1, 0, 3, 0, 0); step();
    chk("mf_r5_rdata", b0.RDATA, 32'hAA22CC44);
    d0(1, 0, 4, 0, 0); step();
    chk("mf_r3_rdata", b0.RDATA, 32'h12345678);
    rst = 1'b1; d0(0, 0, 0, 0, 0); step();
    chk("mf_ack",   32'(b0.ACK),  0);
    chk("mf_rdata", b0.RDATA,     32'h0);
    chk("mf_busy",  32'(b0.BUSY), 1);
    d0(1, 0, 4, 0, 0); step();
    chk("mf_rstreq_ack", 32'(b0.ACK), 0);
    rst = 1'b0;
    cnt = 0;
    ackbad = 0;
    while (b0.BUSY === 1'b1 && cnt < 400) begin
      cnt++;
      d0(cnt[0], 0, 8'(cnt), 0, 0);
      step();
      if (b0.ACK !== 1'b0) ackbad++;
    end
    d0(0, 0, 0, 0, 0);
    chk("mf_busy_cycles", cnt, 256);
    chk("mf_busy_noack",  ackbad, 0);
    step();
    chk("mf_late_ack", 32'(b0.ACK), 0);
    d0(1, 0, 3, 0, 0); step(); d0(0, 0, 0, 0, 0); step();
    chk("mf_clr3_ack",   32'(b0.ACK), 1);
    chk("mf_clr3_rdata", b0.RDATA, 32'h0);
    d0(1, 0, 5, 0, 0); step(); d0(0, 0, 0, 0, 0); step();
    chk("mf_clr5_rdata", b0.RDATA, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_sync_be_pipe.md
Name: mem_sync_be_pipe

Overview:
- Parametrised single-port synchronous word memory with separate read and write data buses (no inout).
- Adds per-byte write enables, a REQ/ACK handshake, a configurable response latency, a reset-time hardware clear sequence with BUSY, and out-of-range address error reporting.
- Used as the next-generation main/scratch memory behind the processor datapath and the testbench loaders.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- DEPTH, 256, number of words; need not be a power of 2.
- ADDR_W, 8, address width; must satisfy 2**ADDR_W >= DEPTH.
- RD_LATENCY, 2, response latency in cycles for every request; legal range 1..4.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  reset, synchronous, active-high.
- REQ  input  1  request valid, sampled at the rising edge of CLK.
- WE  input  1  1 = write, 0 = read; qualified by REQ.
- ADDR  input  ADDR_W  word address.
- WDATA  input  DATA_W  write data.
- BE  input  DATA_W/8  byte enables for writes; bit i covers WDATA[8i+7:8i].
- RDATA  output  DATA_W  read response data.
- ACK  output  1  one-cycle response pulse, one per accepted request, in order.
- ERR  output  1  qualifies ACK: the address was out of range.
- BUSY  output  1  clear sequence in progress; requests are ignored while high.

Behaviour:
- Reset: RST=1 at a rising edge sets state to INIT and clr_cnt=0, flushes the response pipeline, and sets RDATA=0, ACK=0, ERR=0, BUSY=1. While RST stays high, state holds INIT and clr_cnt holds 0.
- States:
  - INIT: each cycle with RST=0 writes 0 to word clr_cnt, then increments clr_cnt. On the edge that clears word DEPTH-1, go to READY.
  - READY: BUSY=0. BUSY is therefore high for exactly DEPTH cycles after RST falls.
- Acceptance: a request is accepted at a rising edge where REQ=1, BUSY=0 and RST=0. One request can be accepted per cycle and back-to-back requests are fully pipelined. REQ during INIT is dropped, with no ACK.
- Write, accepted at edge k:
  - If ADDR < DEPTH, each byte with BE[i]=1 is updated at edge k; other bytes are unchanged.
  - BE=0 is a legal no-op write and is still acknowledged.
- Read, accepted at edge k: the array is sampled at edge k, so a read issued the cycle after a write to the same address returns the new data.
- Response timing: for every accepted request, ACK=1 for exactly the one cycle that follows edge k+RD_LATENCY-1. With RD_LATENCY=1, ACK is high in the cycle immediately after acceptance. Responses leave in acceptance order, with no reordering and no stalls.
- RDATA:
  - Updates only on a read response: the word value, or 0 if ERR.
  - Holds its previous value during write responses and idle cycles.
- ERR: equals 1 with ACK when ADDR >= DEPTH (reads and writes). The array is not modified. ERR=0 whenever ACK=0.
- Reset mid-operation: in-flight responses are discarded, with no ACK after the reset edge. Clearing restarts from word 0. Array contents written before the reset are zeroed by INIT.
- Widths: the address compare is unsigned over ADDR_W bits. clr_cnt is ADDR_W bits and never exceeds DEPTH-1.

Test Plan:
- Reset/clear (DEPTH=256): pulse RST for 2 cycles, then release -> BUSY high for exactly 256 cycles, then 0. A read of address 0xFF then returns RDATA=0x00000000, ACK=1, ERR=0.
- Byte-enable write: write 0xAABBCCDD to address 5 with BE=4'b1111, then 0x11223344 with BE=4'b0101, then read address 5 -> RDATA=0xAA22CC44, arriving 2 cycles after the read is accepted (RD_LATENCY=2).
- Back-to-back pipeline: write address 3 = 0x12345678, then read address 3 on the very next cycle, then read address 4 (0) -> three consecutive ACK pulses with no gap; the second delivers 0x12345678 and the third 0x00000000.
- Out of range (DEPTH=200, ADDR_W=8): write address 250 with 0xFFFFFFFF, then read address 250 -> both ACKs have ERR=1 and the read gives RDATA=0. Reading address 199 afterwards gives ERR=0 and the prior contents.
- Reset mid-flight: issue 3 reads, then assert RST on the cycle after the third is accepted -> no ACK after the reset edge, RDATA=0, BUSY=1 and clearing restarts at word 0. REQ pulses during BUSY produce no ACK.
- Latency sweep: RD_LATENCY=1 and 4, single read of a known word -> ACK in cycle +1 and cycle +4 respectively, with the correct data.
